// File: rtl/dma_channel_ctrl_if.sv
// Shared Data_Bus/Address_Bus/Control/IReady/TReady bus plus the arbiter request/grant pair.
// The master side drives address, control, data and IReady; TReady comes from the addressed slave.
interface dma_channel_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    wire  [DATA_W-1:0] Data_Bus;
    wire  [ADDR_W-1:0] Address_Bus;
    wire               Control;
    wire               IReady;
    wire               TReady;
    logic              bus_req;
    logic              bus_gnt;

    modport master (
        inout  Data_Bus,
        inout  Address_Bus,
        inout  Control,
        inout  IReady,
        input  TReady,
        output bus_req,
        input  bus_gnt
    );

    modport slave (
        inout  Data_Bus,
        input  Address_Bus,
        input  Control,
        input  IReady,
        output TReady
    );
endinterface

// File: rtl/dma_channel_ctrl.sv
// Single-channel DMA master: copies cfg_len words from cfg_src to cfg_dst, one read then one
// write per word, over the four-phase IReady/TReady handshake on the shared bus.
module dma_channel_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   cfg_src,
    input  logic [ADDR_W-1:0]   cfg_dst,
    input  logic [15:0]         cfg_len,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    dma_channel_ctrl_if.master  bus
);

    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle, StReq, StRdSetup, StRdWait, StRdRel, StWrSetup, StWrWait, StWrRel, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [15:0]         count_q, count_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                t_ready;
    logic                in_hs_q;
    logic                in_hs_d;
    logic                drive_addr;
    logic                wr_phase;
    logic                iready_val;

    assign t_ready = (bus.TReady == 1'b1);

    always_comb begin
        in_hs_q = (state_q == StRdWait) || (state_q == StRdRel) ||
                  (state_q == StWrWait) || (state_q == StWrRel);
        in_hs_d = (state_d == StRdWait) || (state_d == StRdRel) ||
                  (state_d == StWrWait) || (state_d == StWrRel);
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        data_d  = data_q;
        done_d  = 1'b0;
        error_d = error_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    error_d = 1'b0;
                    if (cfg_len != 16'd0) begin
                        src_d   = cfg_src;
                        dst_d   = cfg_dst;
                        count_d = cfg_len;
                        state_d = StReq;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (bus.bus_gnt) state_d = StRdSetup;
            end
            StRdSetup: state_d = StRdWait;
            StRdWait: begin
                if (t_ready) begin
                    data_d  = bus.Data_Bus;
                    state_d = StRdRel;
                end
            end
            StRdRel: begin
                if (!t_ready) state_d = StWrSetup;
            end
            StWrSetup: state_d = StWrWait;
            StWrWait: begin
                if (t_ready) state_d = StWrRel;
            end
            StWrRel: begin
                if (!t_ready) begin
                    src_d   = src_q + 1'b1;
                    dst_d   = dst_q + 1'b1;
                    count_d = count_q - 16'd1;
                    if (count_q == 16'd1) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRdSetup;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A completed handshake on the final allowed cycle still wins over the abort.
        if (in_hs_q && (timer_q == TimerW'(TIMEOUT)) && (state_d == state_q)) begin
            state_d = StIdle;
            error_d = 1'b1;
        end

        timer_d = (in_hs_d && (state_d == state_q)) ? timer_q + TimerW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            data_q  <= data_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Bus drives decode straight from state_q so an async reset releases them at once.
    always_comb begin
        drive_addr = (state_q == StRdSetup) || (state_q == StRdWait) || (state_q == StRdRel) ||
                     (state_q == StWrSetup) || (state_q == StWrWait) || (state_q == StWrRel);
        wr_phase   = (state_q == StWrSetup) || (state_q == StWrWait) || (state_q == StWrRel);
        iready_val = (state_q == StRdWait) || (state_q == StWrWait);
    end

    assign bus.Address_Bus = drive_addr ? (wr_phase ? dst_q : src_q) : {ADDR_W{1'bz}};
    assign bus.Control     = drive_addr ? wr_phase : 1'bz;
    assign bus.IReady      = drive_addr ? iready_val : 1'bz;
    assign bus.Data_Bus    = wr_phase ? data_q : {DATA_W{1'bz}};
    assign bus.bus_req     = (state_q != StIdle);

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign error = error_q;

endmodule
